// File: rtl/fir_requant_decim_if.sv
// Stream and control bundle for fir_requant_decim: sample input side, runtime
// controls, and the show-ahead valid/ready output with its status flags.
// The master drives samples and accepts results; the slave is the block itself.
interface fir_requant_decim_if #(
  parameter int IN_W       = 31,
  parameter int OUT_W      = 16,
  parameter int DECIM_MAX  = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(DECIM_MAX);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic                    i_ce;
  logic signed [IN_W-1:0]  i_result;
  logic [CW-1:0]           i_decim;
  logic                    i_flag_clr;
  logic                    i_ready;
  logic                    o_valid;
  logic signed [OUT_W-1:0] o_data;
  logic [LW-1:0]           o_level;
  logic                    o_sat;
  logic                    o_overflow;

  modport master (
    output i_ce, i_result, i_decim, i_flag_clr, i_ready,
    input  o_valid, o_data, o_level, o_sat, o_overflow
  );

  modport slave (
    input  i_ce, i_result, i_decim, i_flag_clr, i_ready,
    output o_valid, o_data, o_level, o_sat, o_overflow
  );
endinterface

// File: rtl/fir_requant_decim.sv
// Requantizer / decimator behind genericfir: rounds half-up, shifts, saturates
// to OUT_W, keeps one of (i_decim+1) strobes and queues the kept samples in a
// small show-ahead FIFO read through a valid/ready handshake.
module fir_requant_decim #(
  parameter int IN_W       = 31,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 12,
  parameter int DECIM_MAX  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  fir_requant_decim_if.slave  bus
);
  localparam int CW = $clog2(DECIM_MAX);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = IN_W + 1;

  // One extra bit so adding the rounding constant can never wrap.
  localparam logic signed [XW-1:0] RND     = (SHIFT > 0) ? (XW'(1) << (SHIFT - 1)) : '0;
  localparam logic signed [XW-1:0] SAT_MAX = XW'((64'sd1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = -SAT_MAX - XW'(1);

  logic signed [XW-1:0]    ext_sum;
  logic signed [XW-1:0]    shifted;
  logic signed [OUT_W-1:0] clamped;
  logic                    clip;

  logic [CW-1:0]           phase;
  logic                    st_valid;
  logic                    st_keep;
  logic                    st_sat;
  logic signed [OUT_W-1:0] st_data;

  logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           count;

  logic full;
  logic pop;
  logic push_req;
  logic push;

  // Round half-up, arithmetic shift, then clamp to the output range.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    clamped = '0;
    clip    = 1'b0;
    ext_sum = $signed({bus.i_result[IN_W-1], bus.i_result}) + RND;
    shifted = ext_sum >>> SHIFT;
    if (shifted > SAT_MAX) begin
      clamped = SAT_MAX[OUT_W-1:0];
      clip    = 1'b1;
    end else if (shifted < SAT_MIN) begin
      clamped = SAT_MIN[OUT_W-1:0];
      clip    = 1'b1;
    end else begin
      clamped = shifted[OUT_W-1:0];
    end
  end

  // Decimation phase and stage-1 capture, both advancing only on a strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!i_rst_n) begin
      phase    <= '0;
      st_valid <= 1'b0;
      st_keep  <= 1'b0;
      st_sat   <= 1'b0;
      st_data  <= '0;
    end else begin
      st_valid <= bus.i_ce;
      if (bus.i_ce) begin
        st_keep <= (phase == '0);
        st_sat  <= clip;
        st_data <= clamped;
        phase   <= (phase >= bus.i_decim) ? '0 : phase + 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full     = (count == LW'(FIFO_DEPTH));
  assign pop      = (count != '0) && bus.i_ready;
  assign push_req = st_valid && st_keep;
  assign push     = push_req && (!full || pop);

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write.
  always_ff @(posedge i_clk) begin
    // NOTE: storage is not reset; occupancy decides validity and the head output is gated while empty.
    if (push) mem[wr_ptr] <= st_data;
  end

  // Sticky status flags; a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_sat      <= 1'b0;
      bus.o_overflow <= 1'b0;
    end else begin
      if (push_req && st_sat)        bus.o_sat <= 1'b1;
      else if (bus.i_flag_clr)       bus.o_sat <= 1'b0;
      if (push_req && full && !pop)  bus.o_overflow <= 1'b1;
      else if (bus.i_flag_clr)       bus.o_overflow <= 1'b0;
    end
  end

  assign bus.o_valid = (count != '0);
  assign bus.o_data  = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.o_level = count;

endmodule

// File: tb/tb_fir_requant_decim.sv
// Self-checking bench for fir_requant_decim: directed scenarios plus random
// traffic, scored against a floor-division reference model and an expected
// output queue drained by an independent monitor.
module tb_fir_requant_decim;
  localparam int IN_W       = 31;
  localparam int OUT_W      = 16;
  localparam int SHIFT      = 12;
  localparam int DECIM_MAX  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam longint MAXV   = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint MINV   = -(64'sd1 <<< (OUT_W - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fir_requant_decim_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM_MAX(DECIM_MAX),
                         .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  fir_requant_decim #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
                      .DECIM_MAX(DECIM_MAX), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: occupancy, flags, decimation phase, one in-flight sample.
  int  lvl_m    = 0;
  bit  sat_m    = 0;
  bit  ovf_m    = 0;
  int  phase_m  = 0;
  bit  stg_v    = 0;
  bit  stg_k    = 0;
  bit  stg_s    = 0;
  int  stg_d    = 0;
  int  cur_decim = 0;
  int  exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round half-up via floor division, then clamp.
  function automatic int requant(input int x, output bit s);
    longint r, d, q;
    d = 64'sd1 <<< SHIFT;
    r = longint'(x) + (d / 2);
    q = (r >= 0) ? (r / d) : -((-r + d - 1) / d);
    s = 1'b0;
    if (q > MAXV) begin q = MAXV; s = 1'b1; end
    else if (q < MINV) begin q = MINV; s = 1'b1; end
    return int'(q);
  endfunction

  function automatic void model_reset();
    lvl_m = 0; sat_m = 0; ovf_m = 0; phase_m = 0;
    stg_v = 0; stg_k = 0; stg_s = 0; stg_d = 0;
    exp_q.delete();
  endfunction

  // One clock: compare post-edge state, then drive the next inputs and
  // advance the reference to what the coming edge should produce.
  task automatic step(input bit ce, input int res, input bit rdy, input bit clr = 1'b0);
    bit pop, pr, ovf_set, sat_set, s;
    @(posedge clk); #1;
    check("level", longint'(bus.o_level), lvl_m);
    check("valid", longint'(bus.o_valid), longint'(lvl_m > 0));
    check("sat", longint'(bus.o_sat), sat_m);
    check("overflow", longint'(bus.o_overflow), ovf_m);

    bus.i_ce       = ce;
    bus.i_result   = res[IN_W-1:0];
    bus.i_ready    = rdy;
    bus.i_flag_clr = clr;
    bus.i_decim    = cur_decim[3:0];

    pop     = (lvl_m > 0) && rdy;
    pr      = stg_v && stg_k;
    ovf_set = 1'b0;
    if (pr) begin
      if (lvl_m < FIFO_DEPTH || pop) begin
        exp_q.push_back(stg_d);
        lvl_m++;
      end else begin
        ovf_set = 1'b1;
      end
    end
    if (pop) lvl_m--;
    sat_set = pr && stg_s;
    sat_m   = sat_set ? 1'b1 : (clr ? 1'b0 : sat_m);
    ovf_m   = ovf_set ? 1'b1 : (clr ? 1'b0 : ovf_m);

    stg_v = ce;
    if (ce) begin
      stg_k   = (phase_m == 0);
      stg_d   = requant(res, s);
      stg_s   = s;
      phase_m = (phase_m >= cur_decim) ? 0 : phase_m + 1;
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, rdy);
  endtask

  // Monitor: every accepted head must match the oldest expected sample.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_valid && bus.i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", longint'($signed(bus.o_data)), 64'sd999999);
        end else begin
          check("data", longint'($signed(bus.o_data)), longint'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    bus.i_ce = 1'b0; bus.i_result = '0; bus.i_decim = '0;
    bus.i_flag_clr = 1'b0; bus.i_ready = 1'b0;
    #12 rst_n = 1'b1;
    check("reset_data", longint'($signed(bus.o_data)), 0);

    // Impulse: single unit strobe then zeros.
    cur_decim = 0;
    step(1'b1, 4096, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b1);
    idle(3, 1'b1);

    // Rounding boundaries.
    step(1'b1, 2048, 1'b1);
    step(1'b1, 2047, 1'b1);
    step(1'b1, -2048, 1'b1);
    step(1'b1, -2049, 1'b1);
    idle(3, 1'b1);

    // Saturation at both rails, then clear.
    step(1'b1, (1 << 30) - 1, 1'b1);
    step(1'b1, -(1 << 30), 1'b1);
    idle(3, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Decimation by 3, then lower the ratio while at phase 2.
    cur_decim = 2;
    for (int k = 1; k <= 9; k++) step(1'b1, k * 4096, 1'b1);
    step(1'b1, 10 * 4096, 1'b1);
    step(1'b1, 11 * 4096, 1'b1);
    cur_decim = 0;
    step(1'b1, 12 * 4096, 1'b1);
    step(1'b1, 13 * 4096, 1'b1);
    idle(4, 1'b1);

    // Backpressure: overfill, release, then sustained push+pop while full.
    for (int k = 1; k <= 6; k++) step(1'b1, k * 4096, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) step(1'b1, k * 4096, 1'b0);
    idle(2, 1'b0);
    for (int k = 5; k <= 10; k++) step(1'b1, k * 4096, 1'b1);
    idle(6, 1'b1);

    // Reset mid-run with three entries queued.
    for (int k = 1; k <= 3; k++) step(1'b1, k * 4096, 1'b0);
    idle(2, 1'b0);
    step(1'b0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", longint'(bus.o_valid), 0);
    check("rst_level", longint'(bus.o_level), 0);
    check("rst_sat", longint'(bus.o_sat), 0);
    check("rst_overflow", longint'(bus.o_overflow), 0);
    check("rst_data", longint'($signed(bus.o_data)), 0);
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    cur_decim = 3;
    step(1'b1, 7 * 4096, 1'b1);
    idle(3, 1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int res;
      if ($urandom_range(0, 49) == 0) cur_decim = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) res = int'($urandom) >>> 1;
      else res = int'($urandom_range(0, 400000)) - 200000;
      step($urandom_range(0, 3) != 0, res, $urandom_range(0, 9) < 7,
           $urandom_range(0, 29) == 0);
    end

    idle(10, 1'b1);
    check("queue_drained", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
